// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg
// Shared definitions for the SPI receive deframer:
//   - state_t and the FSM state encodings (HUNT .. DCRC)
//   - CRC32_POLY / CRC32_INIT constants
//   - crc32_word(): one 32-bit MSB-first CRC-32 step (no reflection, no final XOR)
package spi_frame_pkg;

    typedef logic [2:0] state_t;

    localparam state_t HUNT = 3'd0;
    localparam state_t HDR0 = 3'd1;
    localparam state_t HDR1 = 3'd2;
    localparam state_t HDR2 = 3'd3;
    localparam state_t HCRC = 3'd4;
    localparam state_t DATA = 3'd5;
    localparam state_t DCRC = 3'd6;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    // Shift the whole word through the CRC register, data bit 31 first.
    function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/spi_crc32_word.sv
// spi_crc32_word
// Combinational CRC-32 step over one 32-bit word. The accumulator register
// lives in the parser; this block only computes the next value.
//   crc_in   : current accumulator
//   data_in  : word to fold in
//   crc_out  : accumulator after the word
module spi_crc32_word
    import spi_frame_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data_in,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_word(crc_in, data_in);

endmodule

// File: rtl/spi_frame_parser.sv
// spi_frame_parser
// Word-level receive deframer. Hunts for SOF, captures and CRC-checks a
// three-word header, streams length/4 payload words, then checks the data CRC.
//   clk, rst_n            : clock, async active-low reset
//   rx_data/rx_data_valid : words from the SPI PHY (no back-pressure)
//   pkt_rx_enable         : low forces HUNT and ignores input words
//   pkt_rx_type/id/addr/length : header of the last accepted frame
//   pkt_rx_data/_valid    : payload word stream
//   pkg_rx_start/pkg_rx_end : header accepted / data CRC word consumed
//   header_crc_error, data_crc_error, error : single-cycle error pulses
//   busy                  : parser is inside a frame
// All outputs are registered; pulses appear one cycle after the input word.
module spi_frame_parser
    import spi_frame_pkg::*;
#(
    parameter logic [31:0]    SOF       = 32'h5A5A_A5A5,
    parameter logic [31:0]    MAX_LEN   = 32'h0012_C000,
    parameter int             TOW       = 24,
    parameter logic [TOW-1:0] TO_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data,
    input  logic        rx_data_valid,
    input  logic        pkt_rx_enable,
    output logic [15:0] pkt_rx_type,
    output logic [15:0] pkt_rx_id,
    output logic [31:0] pkt_rx_addr,
    output logic [31:0] pkt_rx_length,
    output logic [31:0] pkt_rx_data,
    output logic        pkt_rx_data_valid,
    output logic        pkg_rx_start,
    output logic        pkg_rx_end,
    output logic        header_crc_error,
    output logic        data_crc_error,
    output logic        error,
    output logic        busy
);

    localparam logic [TOW-1:0] TO_ONE  = {{(TOW-1){1'b0}}, 1'b1};
    // Timeout fires on the idle cycle where the counter would reach TO_CYCLES.
    localparam logic [TOW-1:0] TO_LAST = TO_CYCLES - TO_ONE;

    state_t         state_r,  state_s;
    logic [31:0]    crc_r,    crc_s,   crc_step_s;
    logic [31:0]    sh_w0_r,  sh_w0_s;
    logic [31:0]    sh_addr_r, sh_addr_s;
    logic [31:0]    sh_len_r, sh_len_s;
    logic [29:0]    word_cnt_r, word_cnt_s;
    logic [TOW-1:0] to_cnt_r, to_cnt_s;
    logic [15:0]    type_s, id_s;
    logic [31:0]    addr_s, length_s, data_s;
    logic           data_valid_s, start_s, end_s, hcrc_err_s, dcrc_err_s, error_s;
    logic           timeout_s, len_ok_s;

    spi_crc32_word u_crc (
        .crc_in  (crc_r),
        .data_in (rx_data),
        .crc_out (crc_step_s)
    );

    assign timeout_s = (state_r != HUNT) && !rx_data_valid && (to_cnt_r == TO_LAST);
    assign len_ok_s  = (sh_len_r != 32'd0) && (sh_len_r[1:0] == 2'b00) && (sh_len_r <= MAX_LEN);

    // Next-state, datapath and pulse decode for the frame FSM.
    always_comb begin
        state_s      = state_r;
        crc_s        = crc_r;
        sh_w0_s      = sh_w0_r;
        sh_addr_s    = sh_addr_r;
        sh_len_s     = sh_len_r;
        word_cnt_s   = word_cnt_r;
        type_s       = pkt_rx_type;
        id_s         = pkt_rx_id;
        addr_s       = pkt_rx_addr;
        length_s     = pkt_rx_length;
        data_s       = pkt_rx_data;
        data_valid_s = 1'b0;
        start_s      = 1'b0;
        end_s        = 1'b0;
        hcrc_err_s   = 1'b0;
        dcrc_err_s   = 1'b0;
        error_s      = 1'b0;
        if ((state_r == HUNT) || rx_data_valid) begin
            to_cnt_s = {TOW{1'b0}};
        end else begin
            to_cnt_s = to_cnt_r + TO_ONE;
        end

        if (!pkt_rx_enable) begin
            // Silent abort: no pulses, back to hunting.
            state_s  = HUNT;
            crc_s    = CRC32_INIT;
            to_cnt_s = {TOW{1'b0}};
        end else if (timeout_s) begin
            error_s  = 1'b1;
            state_s  = HUNT;
            crc_s    = CRC32_INIT;
            to_cnt_s = {TOW{1'b0}};
        end else if (rx_data_valid) begin
            case (state_r)
                HUNT: begin
                    crc_s = CRC32_INIT;
                    if (rx_data == SOF) begin
                        state_s = HDR0;
                    end else begin
                        state_s = HUNT;
                    end
                end
                HDR0: begin
                    sh_w0_s = rx_data;
                    crc_s   = crc_step_s;
                    state_s = HDR1;
                end
                HDR1: begin
                    sh_addr_s = rx_data;
                    crc_s     = crc_step_s;
                    state_s   = HDR2;
                end
                HDR2: begin
                    sh_len_s = rx_data;
                    crc_s    = crc_step_s;
                    state_s  = HCRC;
                end
                HCRC: begin
                    crc_s = CRC32_INIT;
                    if (rx_data != crc_r) begin
                        hcrc_err_s = 1'b1;
                        error_s    = 1'b1;
                        state_s    = HUNT;
                    end else if (!len_ok_s) begin
                        error_s = 1'b1;
                        state_s = HUNT;
                    end else begin
                        type_s     = sh_w0_r[31:16];
                        id_s       = sh_w0_r[15:0];
                        addr_s     = sh_addr_r;
                        length_s   = sh_len_r;
                        start_s    = 1'b1;
                        word_cnt_s = sh_len_r[31:2];
                        state_s    = DATA;
                    end
                end
                DATA: begin
                    data_s       = rx_data;
                    data_valid_s = 1'b1;
                    crc_s        = crc_step_s;
                    word_cnt_s   = word_cnt_r - 30'd1;
                    if (word_cnt_r == 30'd1) begin
                        state_s = DCRC;
                    end else begin
                        state_s = DATA;
                    end
                end
                DCRC: begin
                    end_s      = 1'b1;
                    dcrc_err_s = (rx_data != crc_r);
                    crc_s      = CRC32_INIT;
                    state_s    = HUNT;
                end
                default: begin
                    crc_s   = CRC32_INIT;
                    state_s = HUNT;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, accumulator, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r           <= HUNT;
            crc_r             <= CRC32_INIT;
            sh_w0_r           <= 32'd0;
            sh_addr_r         <= 32'd0;
            sh_len_r          <= 32'd0;
            word_cnt_r        <= 30'd0;
            to_cnt_r          <= {TOW{1'b0}};
            pkt_rx_type       <= 16'd0;
            pkt_rx_id         <= 16'd0;
            pkt_rx_addr       <= 32'd0;
            pkt_rx_length     <= 32'd0;
            pkt_rx_data       <= 32'd0;
            pkt_rx_data_valid <= 1'b0;
            pkg_rx_start      <= 1'b0;
            pkg_rx_end        <= 1'b0;
            header_crc_error  <= 1'b0;
            data_crc_error    <= 1'b0;
            error             <= 1'b0;
            busy              <= 1'b0;
        end else begin
            state_r           <= state_s;
            crc_r             <= crc_s;
            sh_w0_r           <= sh_w0_s;
            sh_addr_r         <= sh_addr_s;
            sh_len_r          <= sh_len_s;
            word_cnt_r        <= word_cnt_s;
            to_cnt_r          <= to_cnt_s;
            pkt_rx_type       <= type_s;
            pkt_rx_id         <= id_s;
            pkt_rx_addr       <= addr_s;
            pkt_rx_length     <= length_s;
            pkt_rx_data       <= data_s;
            pkt_rx_data_valid <= data_valid_s;
            pkg_rx_start      <= start_s;
            pkg_rx_end        <= end_s;
            header_crc_error  <= hcrc_err_s;
            data_crc_error    <= dcrc_err_s;
            error             <= error_s;
            busy              <= (state_s != HUNT);
        end
    end

endmodule
